pmem_line_responder: RTL and testbench

- Responder end of the 128-bit cache-line physical-memory interface driven by the L2 cache (pmem_read / pmem_write / pmem_address / pmem_wdata -> pmem_rdata / pmem_resp).
- Services each line request as a sequence of word transfers on a narrow word-wide memory port.
- Gathers read words into a line buffer, or scatters a written line into words.
- Sits between the L2 cache and main memory.

---
 rtl/pmem_line_responder.sv | 172 +++++++++++++++++
 tb/tb_pmem_line_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_responder.sv
// pmem_line_responder
//
// Responder end of the 128-bit cache-line memory interface driven by the L2
// cache. Each line request is broken into NWORDS word transfers on a narrow
// word-wide memory port. Read words are gathered into a line buffer. A written
// line is scattered into words, word 0 being the least significant bits.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   pmem_address      line request address (byte offset bits ignored)
//   pmem_read/write   level line requests, held until pmem_resp
//   pmem_wdata        line write data
//   pmem_rdata        assembled read line, updated when a read completes
//   pmem_resp         one-cycle completion pulse
//   wmem_address      word byte address
//   wmem_read/write   word strobes, held until wmem_resp
//   wmem_wdata        word write data
//   wmem_rdata        word read data, valid with wmem_resp
//   wmem_resp         word completion pulse
//   busy              high whenever a line transfer is in progress
module pmem_line_responder #(
    parameter int LINE_WIDTH = 128,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           pmem_address,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic [15:0]           wmem_address,
    output logic                  wmem_read,
    output logic                  wmem_write,
    output logic [WORD_WIDTH-1:0] wmem_wdata,
    input  logic [WORD_WIDTH-1:0] wmem_rdata,
    input  logic                  wmem_resp,
    output logic                  busy
);

    localparam int NWORDS     = LINE_WIDTH / WORD_WIDTH;
    localparam int CNT_W      = $clog2(NWORDS);
    localparam int LINE_OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int WORD_OFF_W = $clog2(WORD_WIDTH / 8);
    localparam int BASE_W     = 16 - LINE_OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        RD_WORD,
        WR_WORD,
        GAP,
        RESP
    } state_t;

    state_t                  state;
    logic                    is_write;
    logic [BASE_W-1:0]       line_base;
    logic [CNT_W-1:0]        count;
    logic [LINE_WIDTH-1:0]   wr_line;
    logic [LINE_WIDTH-1:0]   rd_buf;
    logic [LINE_WIDTH-1:0]   rd_filled;
    logic                    last_word;
    logic                    unused_addr_bits;

    // The byte offset within a line never reaches memory.
    assign unused_addr_bits = ^pmem_address[LINE_OFF_W-1:0];

    assign last_word = (count == CNT_W'(NWORDS - 1));

    // The counter sits directly above the word byte offset, so it can never
    // carry into the line-base bits.
    function automatic logic [15:0] word_addr(input logic [BASE_W-1:0] base,
                                              input logic [CNT_W-1:0]  cnt);
        return 16'({base, cnt}) << WORD_OFF_W;
    endfunction

    // Read buffer with the word arriving this cycle merged in, so the final
    // word can be presented on pmem_rdata at the same edge that enters RESP.
    always_comb begin
        rd_filled = rd_buf;
        rd_filled[int'(count)*WORD_WIDTH +: WORD_WIDTH] = wmem_rdata;
    end

    // Single FSM. Every output is a register set on the transition into the
    // state that owns it, so strobes and pmem_resp never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            is_write     <= 1'b0;
            line_base    <= '0;
            count        <= '0;
            wr_line      <= '0;
            rd_buf       <= '0;
            pmem_rdata   <= '0;
            pmem_resp    <= 1'b0;
            wmem_address <= '0;
            wmem_read    <= 1'b0;
            wmem_write   <= 1'b0;
            wmem_wdata   <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pmem_resp <= 1'b0;
                    // A write takes priority when both requests are present.
                    if (pmem_write || pmem_read) begin
                        line_base    <= pmem_address[15 -: BASE_W];
                        count        <= '0;
                        is_write     <= pmem_write;
                        wmem_address <= word_addr(pmem_address[15 -: BASE_W], '0);
                        busy         <= 1'b1;
                        if (pmem_write) begin
                            wr_line    <= pmem_wdata;
                            wmem_wdata <= pmem_wdata[WORD_WIDTH-1:0];
                            wmem_write <= 1'b1;
                            state      <= WR_WORD;
                        end else begin
                            wmem_read <= 1'b1;
                            state     <= RD_WORD;
                        end
                    end
                end

                RD_WORD, WR_WORD: begin
                    if (wmem_resp) begin
                        wmem_read  <= 1'b0;
                        wmem_write <= 1'b0;
                        count      <= count + CNT_W'(1);
                        if (state == RD_WORD) begin
                            rd_buf <= rd_filled;
                        end
                        if (last_word) begin
                            pmem_resp <= 1'b1;
                            if (state == RD_WORD) begin
                                pmem_rdata <= rd_filled;
                            end
                            state <= RESP;
                        end else begin
                            state <= GAP;
                        end
                    end
                end

                // One idle cycle between words; the counter has already
                // advanced, so the next word's address and data load here.
                GAP: begin
                    wmem_address <= word_addr(line_base, count);
                    wmem_wdata   <= wr_line[int'(count)*WORD_WIDTH +: WORD_WIDTH];
                    if (is_write) begin
                        wmem_write <= 1'b1;
                        state      <= WR_WORD;
                    end else begin
                        wmem_read <= 1'b1;
                        state     <= RD_WORD;
                    end
                end

                RESP: begin
                    pmem_resp <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_line_responder.sv
// tb_pmem_line_responder
//
// Bench for pmem_line_responder. A word memory with a configurable wait count
// answers the word port. A cycle-arithmetic model predicts every output on
// every cycle from the request, the wait count and the memory contents.
module tb_pmem_line_responder;

    localparam int NW = 8;

    logic         clk;
    logic         reset;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  wmem_address;
    logic         wmem_read;
    logic         wmem_write;
    logic [15:0]  wmem_wdata;
    logic [15:0]  wmem_rdata;
    logic         wmem_resp;
    logic         busy;

    int total = 0;
    int bad = 0;

    // Word memory, indexed by byte address >> 1.
    logic [15:0] mem [0:32767];
    int cur_wait = 0;
    int wait_cnt = 0;
    int n_rd_resp = 0;
    int n_wr_resp = 0;

    // Reference model state.
    int           cyc = 0;
    bit           active = 1'b0;
    int           acc = 0;
    bit           m_wr = 1'b0;
    logic [15:0]  m_base = '0;
    int           m_w = 0;
    logic [127:0] m_wdata = '0;
    logic [127:0] exp_rdata = '0;

    pmem_line_responder dut (
        .clk          (clk),
        .reset        (reset),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .wmem_address (wmem_address),
        .wmem_read    (wmem_read),
        .wmem_write   (wmem_write),
        .wmem_wdata   (wmem_wdata),
        .wmem_rdata   (wmem_rdata),
        .wmem_resp    (wmem_resp),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Word memory: answers a held strobe after cur_wait extra cycles, returns
    // junk on wmem_rdata whenever it is not responding.
    always begin
        @(negedge clk);
        wmem_rdata = 16'($urandom);
        if (wmem_read || wmem_write) begin
            if (wait_cnt >= cur_wait) begin
                wmem_resp = 1'b1;
                wait_cnt  = 0;
                if (wmem_read) begin
                    wmem_rdata = mem[wmem_address[15:1]];
                    n_rd_resp++;
                end else begin
                    mem[wmem_address[15:1]] = wmem_wdata;
                    n_wr_resp++;
                end
            end else begin
                wmem_resp = 1'b0;
                wait_cnt++;
            end
        end else begin
            wmem_resp = 1'b0;
            wait_cnt  = 0;
        end
    end

    // Model: a request accepted at the end of idle cycle "acc" occupies
    // cycles acc+1 .. acc+L with L = NW*(W+2); cycle acc+L is the response.
    always begin
        int ended;
        @(posedge clk);
        ended = cyc;
        cyc   = cyc + 1;
        if (reset) begin
            active    = 1'b0;
            exp_rdata = '0;
        end else if (active) begin
            if (ended - acc == NW * (m_w + 2)) begin
                active = 1'b0;
            end else if (cyc - acc == NW * (m_w + 2) && !m_wr) begin
                for (int j = 0; j < NW; j++) begin
                    exp_rdata[j*16 +: 16] = mem[{m_base[15:4], 3'(j)}];
                end
            end
        end else if (pmem_write || pmem_read) begin
            active  = 1'b1;
            acc     = ended;
            m_wr    = pmem_write;
            m_base  = pmem_address & 16'hFFF0;
            m_w     = cur_wait;
            m_wdata = pmem_wdata;
        end
    end

    // Per-cycle comparison of every output against the model.
    always begin
        int  rel;
        int  k;
        bit  strobe;
        bit  resp;
        @(negedge clk);
        if (cyc >= 1) begin
            rel    = cyc - acc;
            strobe = 1'b0;
            resp   = 1'b0;
            k      = 0;
            if (active) begin
                resp = (rel == NW * (m_w + 2));
                if (!resp && rel >= 1) begin
                    k      = (rel - 1) / (m_w + 2);
                    strobe = ((rel - 1) % (m_w + 2)) <= m_w;
                end
            end
            checkOutput("busy", 128'(busy), 128'(active));
            checkOutput("pmem_resp", 128'(pmem_resp), 128'(resp));
            checkOutput("pmem_rdata", pmem_rdata, exp_rdata);
            checkOutput("wmem_read", 128'(wmem_read), 128'(strobe && !m_wr));
            checkOutput("wmem_write", 128'(wmem_write), 128'(strobe && m_wr));
            if (strobe) begin
                checkOutput("wmem_address", 128'(wmem_address), 128'(m_base + 16'(2 * k)));
                if (m_wr) begin
                    checkOutput("wmem_wdata", 128'(wmem_wdata), 128'(m_wdata[k*16 +: 16]));
                end
            end
        end
    end

    // One line request: raised in an idle cycle (cycle 0), held until
    // pmem_resp, dropped in the response cycle. Returns the response cycle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [127:0] wdata, input int w, output int lat);
        @(negedge clk);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wdata;
        cur_wait     = w;
        lat          = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (pmem_resp) begin
                lat = n;
                break;
            end
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        if (lat < 0) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout waiting for pmem_resp at address %h", addr);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int           lat;
        int           rd0;
        int           wr0;
        logic [127:0] line;

        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'(i * 2);
        end
        reset        = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        wmem_resp    = 1'b0;
        wmem_rdata   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_rdata", pmem_rdata, 128'(0));
        checkOutput("reset_waddr", 128'(wmem_address), 128'(0));
        checkOutput("reset_strobes", 128'({wmem_read, wmem_write, pmem_resp}), 128'(0));

        $display("[TB] zero-wait read of 0x1234");
        applyStimulus(1'b1, 1'b0, 16'h1234, '0, 0, lat);
        checkOutput("rd1234_latency", 128'(lat), 128'(16));
        checkOutput("rd1234_data", pmem_rdata,
                    128'h123E_123C_123A_1238_1236_1234_1232_1230);

        $display("[TB] zero-wait write of 0x4560");
        rd0 = n_rd_resp;
        wr0 = n_wr_resp;
        applyStimulus(1'b0, 1'b1, 16'h4560,
                      128'h7777_6666_5555_4444_3333_2222_1111_0000, 0, lat);
        checkOutput("wr4560_latency", 128'(lat), 128'(16));
        checkOutput("wr4560_reads", 128'(n_rd_resp - rd0), 128'(0));
        checkOutput("wr4560_writes", 128'(n_wr_resp - wr0), 128'(8));
        for (int j = 0; j < NW; j++) begin
            checkOutput("wr4560_mem", 128'(mem[15'h22B0 + 15'(j)]), 128'(16'h1111 * j));
        end
        checkOutput("wr_keeps_rdata", pmem_rdata,
                    128'h123E_123C_123A_1238_1236_1234_1232_1230);

        $display("[TB] 3-wait read of 0x4560");
        applyStimulus(1'b1, 1'b0, 16'h4560, '0, 3, lat);
        checkOutput("rd_w3_latency", 128'(lat), 128'(40));
        checkOutput("rd_w3_data", pmem_rdata,
                    128'h7777_6666_5555_4444_3333_2222_1111_0000);

        $display("[TB] read and write together at 0x8000");
        rd0 = n_rd_resp;
        wr0 = n_wr_resp;
        applyStimulus(1'b1, 1'b1, 16'h8000,
                      128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5, 0, lat);
        checkOutput("both_latency", 128'(lat), 128'(16));
        checkOutput("both_reads", 128'(n_rd_resp - rd0), 128'(0));
        checkOutput("both_writes", 128'(n_wr_resp - wr0), 128'(8));

        $display("[TB] reset during word 3 of a read");
        @(negedge clk);
        pmem_read    = 1'b1;
        pmem_address = 16'h0100;
        cur_wait     = 0;
        repeat (7) @(negedge clk);
        checkOutput("mid_word3_addr", 128'(wmem_address), 128'(16'h0106));
        reset     = 1'b1;
        pmem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid_reset_idle", 128'({wmem_read, wmem_write, busy, pmem_resp}), 128'(0));
        applyStimulus(1'b1, 1'b0, 16'h0010, '0, 0, lat);
        checkOutput("after_reset_latency", 128'(lat), 128'(16));
        checkOutput("after_reset_data", pmem_rdata,
                    128'h001E_001C_001A_0018_0016_0014_0012_0010);

        $display("[TB] back-to-back reads at 0xFFF0 and 0x0000");
        applyStimulus(1'b1, 1'b0, 16'hFFF0, '0, 0, lat);
        checkOutput("rdFFF0_data", pmem_rdata,
                    128'hFFFE_FFFC_FFFA_FFF8_FFF6_FFF4_FFF2_FFF0);
        applyStimulus(1'b1, 1'b0, 16'h0000, '0, 0, lat);
        checkOutput("rd0000_latency", 128'(lat), 128'(16));
        checkOutput("rd0000_data", pmem_rdata,
                    128'h000E_000C_000A_0008_0006_0004_0002_0000);

        $display("[TB] randomized requests");
        for (int t = 0; t < 40; t++) begin
            int w;
            int kind;
            w    = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 5));
            line = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(kind != 0 && kind != 1 ? 1'b1 : 1'b0, kind <= 1 ? 1'b1 : 1'b0,
                          16'($urandom), line, w, lat);
            checkOutput("rand_latency", 128'(lat), 128'(NW * (w + 2)));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
